// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: DEPTH-entry circular FIFO with pre-decoded head fields.
// Optional same-cycle empty bypass when FETCH_BUFFER_BYPASS_EN is defined.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_fault,
  output logic [18:0]              out_dec_field,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Immediates are built as signed 32-bit values, then sign-extended to XLEN.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] ins);
    logic signed [31:0] imm;
    imm = '0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {ins[31:12], 12'b0};
      7'b1101111:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      7'b1110011:
        if (ins[14]) imm = {27'b0, ins[19:15]};
      default: imm = '0;
    endcase
    return XLEN'(imm);
  endfunction

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [DEPTH-1:0] fault_mem;

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            not_empty, not_full, bypass, push_wr, pop_rd;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            head_fault;

  assign not_empty = (count != '0);
  assign not_full  = (count != CW'(DEPTH));
  assign in_ready  = not_full & ~flush;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = ~not_empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = not_empty | bypass;
  // A bypassed entry taken by decode in the same cycle never enters storage.
  assign push_wr   = in_valid & in_ready & ~(bypass & out_ready);
  assign pop_rd    = not_empty & out_ready & ~flush;

  always_comb begin
    head_pc    = pc_mem[rd_ptr];
    head_instr = instr_mem[rd_ptr];
    head_fault = fault_mem[rd_ptr];
    if (bypass) begin
      head_pc    = in_pc;
      head_instr = in_instr;
      head_fault = in_fault;
    end
  end

  assign out_pc        = out_valid ? head_pc : '0;
  assign out_instr     = out_valid ? head_instr : '0;
  assign out_fault     = out_valid & head_fault;
  assign out_dec_field = {out_instr[31:25], out_instr[21:20], out_instr[14:12], out_instr[6:0]};
  assign out_rd        = out_instr[11:7];
  assign out_rs1       = out_instr[19:15];
  assign out_rs2       = out_instr[24:20];
  assign out_imm       = decode_imm(out_instr);
  assign out_count     = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop_rd)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_wr, pop_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_wr) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      fault_mem[wr_ptr] <= in_fault;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4, XLEN=32); bypass checks follow FETCH_BUFFER_BYPASS_EN.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk, rst, flush, in_valid, in_ready, in_fault;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [31:0]     in_instr, out_instr;
  logic            out_valid, out_ready, out_fault;
  logic [18:0]     out_dec_field;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [CW-1:0]   out_count;

  int total = 0;
  int bad   = 0;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_fault(out_fault), .out_dec_field(out_dec_field),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs return to idle afterwards.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    in_fault = fault;
  endtask

  logic [31:0] q_pc[$];
  logic [31:0] q_imm[$];
  int sent, popped, mcount;
  logic do_push, do_pop;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_fault = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ADDI x1,x0,5
    drive(32'h100, 32'h00500093, 1'b0);
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_dec", out_dec_field, 19'h00413);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_imm", out_imm, 5);
    check("addi_pc", out_pc, 32'h100);
    check("addi_cnt", out_count, 1);
    out_ready = 1'b1;
    tick();
    check("pop_empty", out_valid, 0);
    check("pop_cnt", out_count, 0);
    check("idle_imm", out_imm, 0);

    // JAL x0,-4 with a fetch fault, held while decode stalls
    drive(32'h104, 32'hFFDFF06F, 1'b1);
    tick();
    check("jal_imm", out_imm, 32'hFFFFFFFC);
    check("jal_op", out_dec_field[6:0], 7'h6F);
    check("jal_fault", out_fault, 1);
    tick();
    check("jal_hold", out_pc, 32'h104);
    out_ready = 1'b1;
    tick();

    // Fill: SW, BNE -16, LUI, CSRRWI
    drive(32'h200, 32'hFE512C23, 1'b0); tick();
    drive(32'h204, 32'hFE0018E3, 1'b0); tick();
    drive(32'h208, 32'hABCDE1B7, 1'b0); tick();
    drive(32'h20C, 32'h340FD073, 1'b0); tick();
    check("full_ready", in_ready, 0);
    check("full_cnt", out_count, 4);
    check("sw_imm", out_imm, 32'hFFFFFFF8);
    check("sw_rs1", out_rs1, 2);
    check("sw_rs2", out_rs2, 5);
    drive(32'h300, 32'h00000013, 1'b0);
    out_ready = 1'b1;
    #1;
    check("full_pp_ready", in_ready, 0);
    tick();
    check("full_pp_cnt", out_count, 3);
    check("b_pc", out_pc, 32'h204);
    check("b_imm", out_imm, 32'hFFFFFFF0);
    out_ready = 1'b1; tick();
    check("lui_imm", out_imm, 32'hABCDE000);
    check("lui_rd", out_rd, 3);
    out_ready = 1'b1; tick();
    check("csri_imm", out_imm, 32'h1F);
    check("csri_rs1", out_rs1, 31);
    out_ready = 1'b1; tick();
    check("drain_cnt", out_count, 0);
    check("drain_valid", out_valid, 0);

    // ECALL and ADD carry no immediate
    drive(32'h210, 32'h00000073, 1'b0); tick();
    check("ecall_imm", out_imm, 0);
    drive(32'h214, 32'h002081B3, 1'b0); out_ready = 1'b1; tick();
    check("add_imm", out_imm, 0);
    check("add_pc", out_pc, 32'h214);
    out_ready = 1'b1; tick();

    // Stream 10 entries against random decode stalls
    sent = 0; popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
      in_valid  = (sent < 10);
      in_pc     = 32'h500 + 32'(sent * 4);
      in_instr  = {12'(sent + 1), 5'd0, 3'd0, 5'd1, 7'h13};
      in_fault  = 1'b0;
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      mcount  = q_pc.size();
      check("strm_cnt", out_count, mcount);
      do_push = in_valid && (mcount != DEPTH);
      do_pop  = out_ready && (mcount != 0);
`ifdef FETCH_BUFFER_BYPASS_EN
      if (mcount == 0 && in_valid) begin
        check("strm_byp_pc", out_pc, in_pc);
        if (out_ready) begin
          popped++;
          sent++;
          do_push = 1'b0;
        end
      end
`endif
      if (do_pop) begin
        check("strm_pc", out_pc, q_pc[0]);
        check("strm_imm", out_imm, q_imm[0]);
        void'(q_pc.pop_front());
        void'(q_imm.pop_front());
        popped++;
      end
      if (do_push) begin
        q_pc.push_back(in_pc);
        q_imm.push_back(32'(sent + 1));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("strm_done", popped, 10);
    check("strm_empty", out_count, 0);

    // Flush with two entries held and a push offered in the flush cycle
    drive(32'h400, 32'h00000013, 1'b0); tick();
    drive(32'h404, 32'h00000013, 1'b0); tick();
    drive(32'h408, 32'h00000013, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_cnt", out_count, 0);
    tick();
    check("flush_gone", out_valid, 0);
    drive(32'h40C, 32'h00000013, 1'b0); tick();
    check("post_flush_pc", out_pc, 32'h40C);
    out_ready = 1'b1; tick();

    // Asynchronous reset with three entries queued
    drive(32'h600, 32'h00000013, 1'b0); tick();
    drive(32'h604, 32'h00000013, 1'b0); tick();
    drive(32'h608, 32'h00000013, 1'b0); tick();
    check("pre_rst_cnt", out_count, 3);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_cnt", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_cnt", out_count, 0);

    // Empty buffer, entry offered with decode ready
    drive(32'h700, 32'h00500093, 1'b0);
    out_ready = 1'b1;
    #1;
`ifdef FETCH_BUFFER_BYPASS_EN
    check("byp_valid", out_valid, 1);
    check("byp_pc", out_pc, 32'h700);
    check("byp_imm", out_imm, 5);
    tick();
    check("byp_cnt", out_count, 0);
    check("byp_after", out_valid, 0);
`else
    check("nobyp_valid", out_valid, 0);
    tick();
    check("nobyp_cnt", out_count, 1);
    check("nobyp_pc", out_pc, 32'h700);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch unit and the decode stage.
- Buffers fetched {pc, instruction, fault} entries in a DEPTH-entry circular FIFO with valid/ready handshakes on both sides.
- Presents the head entry to decode with pre-extracted fields: the 19-bit decoder pattern {instr[31:25], instr[21:20], instr[14:12], instr[6:0]}, rd/rs1/rs2 and the sign-extended immediate.
- Absorbs fetch/decode rate mismatch and is flushed on pipeline redirect.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- XLEN, 32, width of pc, instruction and immediate.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous reset, active-high
- flush  input  1  drop all entries; fetch is being redirected
- in_valid  input  1  fetch presents an entry
- in_ready  output  1  buffer accepts an entry this cycle
- in_pc  input  XLEN  pc of the fetched instruction
- in_instr  input  32  raw instruction word
- in_fault  input  1  fetch access fault for this entry
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  XLEN  head pc
- out_instr  output  32  head instruction word
- out_fault  output  1  head fault flag
- out_dec_field  output  19  {instr[31:25], instr[21:20], instr[14:12], instr[6:0]} of head
- out_rd  output  5  instr[11:7]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_imm  output  XLEN  decoded immediate of head
- out_count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, while rst=1): rd_ptr=0, wr_ptr=0, count=0 -> out_valid=0, in_ready=1, out_count=0. Storage is not reset; all out_* data outputs are 0 while out_valid=0.
- Push when in_valid & in_ready; pop when out_valid & out_ready. Both occur on the same rising edge.
- in_ready = (count != DEPTH) & ~flush. It is registered-state only, with no combinational dependence on out_ready. When full, in_ready=0 even if a pop occurs that cycle.
- out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible at out_* after edge N (one cycle), unless BYPASS_EN is defined.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are distinguishable.
- flush=1: at the next edge pointers and count clear to 0. Any push or pop in that cycle is discarded; decode must ignore a handshake when flush=1. out_valid=0 from the next cycle.
- Data outputs are combinational from the head entry and held stable while out_valid=1 & out_ready=0.
- out_imm by head opcode (instr[6:0]); sx = sign-extend to XLEN:
  - 0000011, 0010011, 1100111 (I-type): sx(instr[31:20])
  - 0100011 (S-type): sx({instr[31:25], instr[11:7]})
  - 1100011 (B-type): sx({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 0110111, 0010111 (U-type): {instr[31:12], 12'b0}
  - 1101111 (J-type): sx({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 1110011 with instr[14]=1 (CSR immediate forms): zero-extend instr[19:15]
  - all other opcodes: 0
- A faulted entry is buffered and delivered like any other; out_fault is passed through and decode raises the exception.

Optional Feature:
- Macro FETCH_BUFFER_BYPASS_EN.
- Defined: when count=0 and in_valid=1 and flush=0, out_valid=1 in the same cycle and out_* is driven from in_*. If out_ready=1, the entry is consumed without being written (pointers and count unchanged). If out_ready=0, it is written normally.
- Not defined: minimum latency is one cycle, and out_* is driven only from storage.

Test Plan:
- Reset mid-operation: 3 entries queued, assert rst -> out_valid=0, in_ready=1, out_count=0 immediately (async); after release, empty.
- Push 0x00500093 (ADDI x1,x0,5) at pc 0x100 -> next cycle out_valid=1, out_dec_field=19'h00413, out_rd=1, out_rs1=0, out_imm=5, out_pc=0x100.
- Push 0xFFDFF06F (JAL x0,-4) -> out_imm=0xFFFFFFFC, out_dec_field[6:0]=7'h6F.
- DEPTH=4, out_ready=0, push 4 entries -> in_ready=0 and out_count=4. Then push+pop while full -> push refused, count=3. Then stream 10 entries with random out_ready -> pops in order, pointer wrap verified.
- Flush with in_valid=1 and 2 entries held -> next cycle out_valid=0, count=0, the flushed-cycle entry is never output.
- BYPASS_EN defined, empty, in_valid=1, out_ready=1 -> out_valid=1 in the same cycle, count stays 0.
